// File: rtl/cla_seq_add_ctrl.sv
// Sequential WIDTH-bit add/subtract that reuses one 4-bit carry-lookahead slice, LSB nibble first.
// done pulses NSLICE cycles after the accept edge; start is ignored while busy (no queuing).
module cla_seq_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             all_prop
);

    localparam int NSLICE = WIDTH / 4;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
            $error("cla_seq_add_ctrl: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry;
    logic             prop_acc;
    logic [IDX_W-1:0] idx;

    logic [3:0] sl_a;
    logic [3:0] sl_b;
    logic [3:0] sl_p;
    logic [3:0] sl_g;
    logic [3:0] sl_c;
    logic [3:0] sl_s;
    logic       grp_p;
    logic       grp_g;
    logic       carry_nxt;
    logic       last;

    // One CLA slice; its carry-in comes only from the carry register.
    always_comb begin
        sl_a    = a_r[4*idx +: 4];
        sl_b    = b_r[4*idx +: 4];
        sl_p    = sl_a ^ sl_b;
        sl_g    = sl_a & sl_b;
        sl_c[0] = carry;
        sl_c[1] = sl_g[0] | (sl_p[0] & carry);
        sl_c[2] = sl_g[1] | (sl_p[1] & sl_g[0]) | (sl_p[1] & sl_p[0] & carry);
        sl_c[3] = sl_g[2] | (sl_p[2] & sl_g[1]) | (sl_p[2] & sl_p[1] & sl_g[0])
                | (sl_p[2] & sl_p[1] & sl_p[0] & carry);
        grp_p   = &sl_p;
        grp_g   = sl_g[3] | (sl_p[3] & sl_g[2]) | (sl_p[3] & sl_p[2] & sl_g[1])
                | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0]);
        sl_s    = sl_p ^ sl_c;
        carry_nxt = grp_g | (grp_p & carry);
        last    = (idx == IDX_W'(NSLICE - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
            all_prop <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            carry    <= 1'b0;
            prop_acc <= 1'b0;
            idx      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r      <= a;
                        b_r      <= sub ? ~b : b;
                        carry    <= sub ? 1'b1 : cin;
                        idx      <= '0;
                        prop_acc <= 1'b1;
                        sum      <= '0;
                        cout     <= 1'b0;
                        ovf      <= 1'b0;
                        all_prop <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum[4*idx +: 4] <= sl_s;
                    carry    <= carry_nxt;
                    prop_acc <= prop_acc & grp_p;
                    idx      <= idx + 1'b1;
                    if (last) begin
                        // sl_s[3] is the result MSB being written on this edge.
                        cout     <= carry_nxt;
                        all_prop <= prop_acc & grp_p;
                        ovf      <= (a_r[WIDTH-1] == b_r[WIDTH-1]) & (sl_s[3] != a_r[WIDTH-1]);
                        idx      <= '0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_add_ctrl.sv
// Bench for cla_seq_add_ctrl: directed table, random ops against an arithmetic model,
// and hand-written sequences for held start, mid-op reset and a 32-bit instance.
module tb_cla_seq_add_ctrl;

    logic        clk;
    logic        rst;
    logic        start16, sub16, cin16;
    logic [15:0] a16, b16;
    logic        busy16, done16, cout16, ovf16, allp16;
    logic [15:0] sum16;
    logic        start32, sub32, cin32;
    logic [31:0] a32, b32;
    logic        busy32, done32, cout32, ovf32, allp32;
    logic [31:0] sum32;

    int n_chk;
    int n_pass;

    cla_seq_add_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .cin(cin16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .sum(sum16),
        .cout(cout16), .ovf(ovf16), .all_prop(allp16)
    );

    cla_seq_add_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .sub(sub32), .cin(cin32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .sum(sum32),
        .cout(cout32), .ovf(ovf32), .all_prop(allp32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] e_sum;
        logic        e_cout;
        logic        e_ovf;
        logic        e_allp;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, req);
    endtask

    // Reference: whole-word arithmetic, overflow from the signed result range.
    task automatic model16(input logic [15:0] a, input logic [15:0] b, input logic s,
                           input logic ci, output logic [15:0] r, output logic co,
                           output logic ov, output logic ap);
        logic [15:0] be;
        logic [16:0] full;
        longint      sr;
        be   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + (s ? 17'd1 : {16'd0, ci});
        r    = full[15:0];
        co   = full[16];
        if (s) sr = longint'($signed(a)) - longint'($signed(b));
        else   sr = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
        ov   = (sr > 32767) || (sr < -32768);
        ap   = ((a ^ be) == 16'hFFFF);
    endtask

    // Starts one op on the 16-bit unit from IDLE and waits (bounded) for done.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic ci, output int lat, output logic bsy0);
        @(negedge clk);
        a16 = a; b16 = b; sub16 = s; cin16 = ci; start16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        bsy0 = busy16;
        for (lat = 1; lat <= 20; lat++) begin
            @(negedge clk);
            if (done16) break;
        end
    endtask

    vec_t        vecs[9];
    int          lat;
    logic        bsy0;
    logic [15:0] m_sum;
    logic        m_cout, m_ovf, m_allp;
    int          done_cnt;
    int          done_at[$];

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1'b1;
        start16 = 0; sub16 = 0; cin16 = 0; a16 = '0; b16 = '0;
        start32 = 0; sub32 = 0; cin32 = 0; a32 = '0; b32 = '0;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000D, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_busy", busy16, 0);
        chk("rst_done", done16, 0);
        chk("rst_sum", sum16, 0);
        chk("rst_flags", {cout16, ovf16, allp16}, 0);
        chk("rst32_busy_sum", {busy32, sum32}, 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run16(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, lat, bsy0);
            chk($sformatf("vec%0d_sum", i), sum16, vecs[i].e_sum);
            chk($sformatf("vec%0d_cout", i), cout16, vecs[i].e_cout);
            chk($sformatf("vec%0d_ovf", i), ovf16, vecs[i].e_ovf);
            chk($sformatf("vec%0d_allp", i), allp16, vecs[i].e_allp);
            chk($sformatf("vec%0d_latency", i), lat, 4);
            chk($sformatf("vec%0d_busy_run", i), bsy0, 1);
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), done16, 0);
            chk($sformatf("vec%0d_busy_idle", i), busy16, 0);
            chk($sformatf("vec%0d_sum_held", i), sum16, vecs[i].e_sum);
        end

        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra, rb;
            logic        rs, rc;
            ra = 16'($urandom); rb = 16'($urandom);
            rs = 1'($urandom); rc = 1'($urandom);
            if (i % 8 == 0) rb = ~ra;
            model16(ra, rb, rs, rc, m_sum, m_cout, m_ovf, m_allp);
            run16(ra, rb, rs, rc, lat, bsy0);
            chk($sformatf("rnd%0d_sum", i), sum16, m_sum);
            chk($sformatf("rnd%0d_flags", i), {cout16, ovf16, allp16}, {m_cout, m_ovf, m_allp});
            chk($sformatf("rnd%0d_latency", i), lat, 4);
        end

        // start held high; operand noise during RUN; next accept on the first IDLE edge.
        @(negedge clk);
        a16 = 16'h1234; b16 = 16'h4321; sub16 = 0; cin16 = 0; start16 = 1'b1;
        @(posedge clk);
        done_cnt = 0;
        done_at.delete();
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            if (done16) begin
                done_cnt++;
                done_at.push_back(c);
                if (done_cnt == 1) chk("held_first_sum", sum16, 16'h5555);
                if (done_cnt == 2) chk("held_second_sum", sum16, 16'h0003);
            end
            if (c < 4) begin
                a16 = 16'($urandom); b16 = 16'($urandom);
                sub16 = 1'($urandom); cin16 = 1'($urandom);
            end
            if (c == 4) begin
                a16 = 16'h0001; b16 = 16'h0002; sub16 = 0; cin16 = 0;
            end
            if (c == 5) chk("held_busy_idle_gap", busy16, 0);
            if (c == 6) begin
                chk("held_busy_reaccept", busy16, 1);
                start16 = 1'b0;
            end
        end
        chk("held_done_count", done_cnt, 2);
        chk("held_first_done_cycle", (done_at.size() > 0) ? done_at[0] : -1, 4);
        chk("held_second_done_cycle", (done_at.size() > 1) ? done_at[1] : -1, 10);

        // Reset landing on the second processing edge of an operation.
        @(negedge clk);
        a16 = 16'hFFFF; b16 = 16'h0001; sub16 = 0; cin16 = 0; start16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy16, 0);
        chk("midrst_done", done16, 0);
        chk("midrst_sum", sum16, 0);
        chk("midrst_flags", {cout16, ovf16, allp16}, 0);
        rst = 1'b0;
        done_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done16 || busy16) done_cnt++;
        end
        chk("midrst_abandoned", done_cnt, 0);
        run16(16'h0001, 16'h0001, 1'b0, 1'b0, lat, bsy0);
        chk("postrst_sum", sum16, 16'h0002);
        chk("postrst_latency", lat, 4);

        // 32-bit instance: full carry ripple across eight nibbles.
        @(negedge clk);
        a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; sub32 = 0; cin32 = 0; start32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        for (lat = 1; lat <= 30; lat++) begin
            @(negedge clk);
            if (done32) break;
        end
        chk("w32_sum", sum32, 32'h0000_0000);
        chk("w32_cout", cout32, 1);
        chk("w32_ovf", ovf32, 0);
        chk("w32_latency", lat, 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
